display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-anode 7-segment display, sitting directly downstream of `BinToBCD`. It latches the four BCD digits (`un`, `dec`, `cent`, `milh`) on a load strobe and shares the single segment bus among the four digits, one at a time. Each digit slot starts with a dead-time blank to suppress ghosting. The block also provides optional leading-zero blanking, per-digit decimal point and a frame-complete tick.

---
 rtl/display_pkg.sv | 31 +++
 rtl/bcd_to_seg7.sv | 25 ++
 rtl/display_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared segment codes, anode constants and types for the 4-digit scan controller.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_ERR   = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] milh;
        logic [3:0] cent;
        logic [3:0] dec;
        logic [3:0] un;
        logic [3:0] dp_en;
    } digits_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show "E".
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan of four latched BCD digits onto one common-anode segment bus.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 500
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] un,
    input  logic [3:0] dec,
    input  logic [3:0] cent,
    input  logic [3:0] milh,
    input  logic       load,
    input  logic       blank_lz,
    input  logic [3:0] dp_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_LAST      = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_DEAD_LAST = CW'(DEAD - 1);

    digits_t       latch_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    state_t        state_q, state_d;

    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick_q, tick_d;

    logic [3:0]    digit;
    logic          lz_blank;
    logic [6:0]    seg_dec;

    // Slot timing: dead-time blank first, then drive until the wrap.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        state_d = state_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            state_d = S_BLANK;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_DEAD_LAST) begin
                state_d = S_DRIVE;
            end
        end
    end

    // A higher digit is blanked only when it and every digit above it are zero.
    always_comb begin
        digit    = latch_q.un;
        lz_blank = 1'b0;
        case (idx_q)
            2'd0: digit = latch_q.un;
            2'd1: begin
                digit    = latch_q.dec;
                lz_blank = blank_lz && (latch_q.milh == 4'd0) && (latch_q.cent == 4'd0)
                           && (latch_q.dec == 4'd0);
            end
            2'd2: begin
                digit    = latch_q.cent;
                lz_blank = blank_lz && (latch_q.milh == 4'd0) && (latch_q.cent == 4'd0);
            end
            default: begin
                digit    = latch_q.milh;
                lz_blank = blank_lz && (latch_q.milh == 4'd0);
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd_i (digit),
        .seg_o (seg_dec)
    );

    always_comb begin
        an_d   = AN_OFF;
        seg_d  = SEG_BLANK;
        dp_d   = 1'b1;
        if ((state_q == S_DRIVE) && !lz_blank) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_dec;
            dp_d  = ~latch_q.dp_en[idx_q];
        end
        tick_d = (idx_q == 2'd3) && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            latch_q <= '0;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            state_q <= S_BLANK;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            if (load) begin
                latch_q <= '{milh: milh, cent: cent, dec: dec, un: un, dp_en: dp_en};
            end
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: frame-position reference model, directed table and corner sequences.
module tb_display_scan_ctrl;

    localparam int P = 8;
    localparam int D = 2;

    logic       clk = 1'b0;
    logic       rst_n, load, blank_lz;
    logic [3:0] un, dec, cent, milh, dp_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, frame_tick;

    always #5 clk = ~clk;

    display_scan_ctrl #(.PRESCALE(P), .DEAD(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .un         (un),
        .dec        (dec),
        .cent       (cent),
        .milh       (milh),
        .load       (load),
        .blank_lz   (blank_lz),
        .dp_en      (dp_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: cycles elapsed since reset determine slot and phase.
    int         p;
    logic [3:0] m_dig [4];
    logic [3:0] m_dp;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_tick;
    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int   s, c;
        logic blk, lead;
        if (!rst_n) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
            p = 0;
            for (int k = 0; k < 4; k++) m_dig[k] = 4'd0;
            m_dp = 4'd0;
        end else begin
            s    = (p / P) % 4;
            c    = p % P;
            blk  = (c < D);
            if (blank_lz && s != 0) begin
                lead = 1'b1;
                for (int k = s; k < 4; k++) if (m_dig[k] != 4'd0) lead = 1'b0;
                blk = blk | lead;
            end
            if (blk) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an  = 4'hF;
                e_an[s] = 1'b0;
                e_seg = segtab[m_dig[s]];
                e_dp  = ~m_dp[s];
            end
            e_tick = (s == 3) && (c == P - 1);
            p++;
            if (load) begin
                m_dig[0] = un; m_dig[1] = dec; m_dig[2] = cent; m_dig[3] = milh;
                m_dp = dp_en;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("scan", {20'd0, an, seg, dp, frame_tick}, {20'd0, e_an, e_seg, e_dp, e_tick});
    endtask

    task automatic wait_frame_tick(input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            n++;
            if (frame_tick === 1'b1) return;
        end
        vectors++;
        errors++;
        $display("FAIL frame_tick_timeout: no tick within %0d cycles", limit);
        n = -1;
    endtask

    task automatic set_digits(input logic [3:0] m, input logic [3:0] c, input logic [3:0] d,
                              input logic [3:0] u);
        milh = m; cent = c; dec = d; un = u;
    endtask

    typedef struct {
        logic [3:0]      milh, cent, dec, un, dpe;
        logic            blz;
        logic [3:0][6:0] seg;
        logic [3:0]      dpx;
    } vec_t;

    vec_t tbl [8];
    int   n;

    initial begin
        rst_n = 1'b0; load = 1'b0; blank_lz = 1'b0; dp_en = 4'd0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);

        tbl[0] = '{4'd2, 4'd5, 4'd7, 4'd8, 4'b0000, 1'b0, {7'h24, 7'h12, 7'h78, 7'h00}, 4'b1111};
        tbl[1] = '{4'd0, 4'd0, 4'd0, 4'd7, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1111};
        tbl[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        tbl[3] = '{4'd0, 4'd0, 4'd0, 4'd7, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h78}, 4'b1111};
        tbl[4] = '{4'd0, 4'd0, 4'd0, 4'hC, 4'b0001, 1'b0, {7'h40, 7'h40, 7'h40, 7'h06}, 4'b1110};
        tbl[5] = '{4'd1, 4'd0, 4'd3, 4'd0, 4'b0000, 1'b1, {7'h79, 7'h40, 7'h30, 7'h40}, 4'b1111};
        tbl[6] = '{4'd0, 4'd0, 4'd5, 4'd0, 4'b1010, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1101};
        tbl[7] = '{4'd9, 4'd6, 4'd4, 4'd1, 4'b1111, 1'b1, {7'h10, 7'h02, 7'h19, 7'h79}, 4'b0000};

        // Reset held three cycles, then the first anode comes on two cycles after release.
        repeat (3) begin
            tick();
            check("rst_an", {28'd0, an}, 32'hF);
        end
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_blank", {28'd0, an}, 32'hF);
        tick();
        check("first_anode", {28'd0, an}, 32'hE);

        foreach (tbl[t]) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            set_digits(tbl[t].milh, tbl[t].cent, tbl[t].dec, tbl[t].un);
            dp_en = tbl[t].dpe;
            blank_lz = tbl[t].blz;
            load = 1'b1;
            tick();
            load = 1'b0;
            wait_frame_tick(64, n);
            for (int j = 0; j < 4 * P; j++) begin
                tick();
                if (j % P == 4) begin
                    check($sformatf("tbl%0d_seg_s%0d", t, j / P), {25'd0, seg},
                          {25'd0, tbl[t].seg[j / P]});
                    check($sformatf("tbl%0d_an_s%0d", t, j / P), {28'd0, an},
                          (tbl[t].seg[j / P] == 7'h7F) ? 32'hF : {28'd0, ~(4'b0001 << (j / P))});
                    check($sformatf("tbl%0d_dp_s%0d", t, j / P), {31'd0, dp},
                          {31'd0, tbl[t].dpx[j / P]});
                end
            end
        end

        // Frame period with 2578 displayed.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        blank_lz = 1'b0;
        dp_en = 4'd0;
        set_digits(4'd2, 4'd5, 4'd7, 4'd8);
        load = 1'b1;
        tick();
        load = 1'b0;
        wait_frame_tick(64, n);
        wait_frame_tick(64, n);
        check("frame_period", n, 4 * P);

        // Load of 1234 at phase 4 of slot 0.
        repeat (4) tick();
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("midload_before", {25'd0, seg}, 32'h00);
        tick();
        check("midload_after_seg", {25'd0, seg}, 32'h19);
        check("midload_after_an", {28'd0, an}, 32'hE);

        // Reset asserted while slot 2 is driving.
        repeat (15) tick();
        check("pre_rst_an", {28'd0, an}, 32'hB);
        rst_n = 1'b0;
        tick();
        check("rst_mid_an", {28'd0, an}, 32'hF);
        check("rst_mid_seg", {25'd0, seg}, 32'h7F);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_seg", {25'd0, seg}, 32'h40);
        check("post_rst_an", {28'd0, an}, 32'hE);
        repeat (4 * P) tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            load = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 39) == 0) blank_lz = ~blank_lz;
            milh = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            cent = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            dec  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            un   = 4'($urandom_range(0, 15));
            dp_en = 4'($urandom_range(0, 15));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
